// File: rtl/fpu_wb_arbiter.sv
// Arbitrates FPU ALU results and FP load data onto the single FP register-file write port, and holds fflags/frm.
// Latency: one cycle from handshake to f_wen/f_rd/f_w_data; readies are combinational from the valids.
// Backpressure: wb_stall or reset holds both readies low; a contested cycle goes to the requester named by prio.
module fpu_wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [4:0]        alu_flags,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4:0]        ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wb_stall,
  input  logic              csr_we,
  input  logic [1:0]        csr_sel,
  input  logic [7:0]        csr_wdata,
  output logic              f_wen,
  output logic [4:0]        f_rd,
  output logic [DATA_W-1:0] f_w_data,
  output logic [4:0]        f_flags,
  output logic [2:0]        f_frm_out
);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic       prio;
  logic       grant_alu;
  logic       grant_ld;
  logic       port_free;
  wb_t        wb_next;
  logic [4:0] flags_next;
  logic [2:0] frm_next;

  assign port_free = nrst && !wb_stall;

  // prio only matters when both requesters are valid in the same cycle
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (port_free) begin
      if (alu_valid && ld_valid) begin
        grant_alu = !prio;
        grant_ld  = prio;
      end else begin
        grant_alu = alu_valid;
        grant_ld  = ld_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;

  always_comb begin
    wb_next.rd   = f_rd;
    wb_next.data = f_w_data;
    if (grant_alu) begin
      wb_next.rd   = alu_rd;
      wb_next.data = alu_data;
    end else if (grant_ld) begin
      wb_next.rd   = ld_rd;
      wb_next.data = ld_data;
    end
  end

  // fcsr packs frm in [7:5]; a bare frm write takes it from [2:0]
  always_comb begin
    flags_next = f_flags;
    frm_next   = f_frm_out;
    if (csr_we) begin
      case (csr_sel)
        2'b01: flags_next = csr_wdata[4:0];
        2'b10: frm_next   = csr_wdata[2:0];
        2'b11: begin
          flags_next = csr_wdata[4:0];
          frm_next   = csr_wdata[7:5];
        end
        default: ;
      endcase
    end
    if (grant_alu) flags_next = flags_next | alu_flags;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      f_wen     <= 1'b0;
      f_rd      <= '0;
      f_w_data  <= '0;
      f_flags   <= '0;
      f_frm_out <= '0;
      prio      <= 1'b0;
    end else begin
      f_wen     <= grant_alu || grant_ld;
      f_rd      <= wb_next.rd;
      f_w_data  <= wb_next.data;
      f_flags   <= flags_next;
      f_frm_out <= frm_next;
      if (grant_alu)     prio <= 1'b1;
      else if (grant_ld) prio <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Randomized and directed bench for fpu_wb_arbiter against a transaction-level model.
module tb_fpu_wb_arbiter;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              nrst;
  logic              alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]        alu_rd, ld_rd, alu_flags;
  logic [DATA_W-1:0] alu_data, ld_data;
  logic              wb_stall, csr_we;
  logic [1:0]        csr_sel;
  logic [7:0]        csr_wdata;
  logic              f_wen;
  logic [4:0]        f_rd, f_flags;
  logic [DATA_W-1:0] f_w_data;
  logic [2:0]        f_frm_out;

  int total = 0;
  int bad   = 0;

  // model state: who goes next on a tie, and what the write port / CSRs must show
  bit          m_ld_next;
  bit          m_wen;
  bit [4:0]    m_rd, m_flags;
  bit [31:0]   m_data;
  bit [2:0]    m_frm;

  fpu_wb_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .nrst(nrst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_flags(alu_flags),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_stall(wb_stall), .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
    .f_wen(f_wen), .f_rd(f_rd), .f_w_data(f_w_data),
    .f_flags(f_flags), .f_frm_out(f_frm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0; alu_flags = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    wb_stall = 0; csr_we = 0; csr_sel = 0; csr_wdata = 0;
  endtask

  task automatic chk_outputs();
    chk("f_wen", f_wen, m_wen);
    chk("f_rd", f_rd, m_rd);
    chk("f_w_data", f_w_data, m_data);
    chk("f_flags", f_flags, m_flags);
    chk("f_frm_out", f_frm_out, m_frm);
  endtask

  // one clock: check readies for the current inputs, advance the model, check registered outputs
  task automatic tick();
    bit ea, el;
    #1;
    ea = 0; el = 0;
    if (!wb_stall) begin
      if (alu_valid && ld_valid) begin
        if (m_ld_next) el = 1; else ea = 1;
      end else begin
        ea = alu_valid;
        el = ld_valid;
      end
    end
    chk("alu_ready", alu_ready, ea);
    chk("ld_ready", ld_ready, el);
    m_wen = ea || el;
    if (ea) begin m_rd = alu_rd; m_data = alu_data; m_ld_next = 1; end
    else if (el) begin m_rd = ld_rd; m_data = ld_data; m_ld_next = 0; end
    if (csr_we) begin
      if (csr_sel == 2'b01) m_flags = csr_wdata[4:0];
      if (csr_sel == 2'b10) m_frm = csr_wdata[2:0];
      if (csr_sel == 2'b11) begin m_flags = csr_wdata[4:0]; m_frm = csr_wdata[7:5]; end
    end
    if (ea) m_flags = m_flags | alu_flags;
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic do_reset();
    nrst = 0;
    m_ld_next = 0; m_wen = 0; m_rd = 0; m_data = 0; m_flags = 0; m_frm = 0;
    #1;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk_outputs();
    @(posedge clk);
    #1;
    chk_outputs();
    idle();
    nrst = 1;
  endtask

  initial begin
    idle();
    nrst = 1;
    #2;
    do_reset();
    chk("reset_wen_literal", f_wen, 0);
    chk("reset_frm_literal", f_frm_out, 0);

    // reset lands while an alu handshake is on the wires
    alu_valid = 1; alu_rd = 3; alu_data = 32'h1234_5678; alu_flags = 5'b11111;
    #1;
    chk("midwrite_alu_ready", alu_ready, 1);
    do_reset();
    chk("midwrite_wen", f_wen, 0);
    chk("midwrite_flags", f_flags, 0);
    tick();

    // conflict: alternation alu, ld, alu, ld
    alu_valid = 1; alu_rd = 1; alu_data = 32'h3F80_0000;
    ld_valid = 1; ld_rd = 2; ld_data = 32'h4000_0000;
    tick(); chk("conf1_rd", f_rd, 1); chk("conf1_data", f_w_data, 32'h3F80_0000);
    tick(); chk("conf2_rd", f_rd, 2); chk("conf2_data", f_w_data, 32'h4000_0000);
    tick(); chk("conf3_rd", f_rd, 1);
    tick(); chk("conf4_rd", f_rd, 2);

    // stall with both valid, then release goes to alu
    do_reset();
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA; ld_valid = 1; ld_rd = 2; ld_data = 32'hB;
    wb_stall = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("stall_wen", f_wen, 0); end
    wb_stall = 0;
    tick(); chk("release_wen", f_wen, 1); chk("release_rd", f_rd, 1);
    idle();
    tick();

    // flag accrual and CSR/alu collision
    do_reset();
    alu_valid = 1; alu_rd = 7; alu_flags = 5'b00001; tick();
    alu_flags = 5'b10000; tick();
    chk("flags_accrue", f_flags, 5'b10001);
    alu_flags = 5'b00100; csr_we = 1; csr_sel = 2'b01; csr_wdata = 8'h00; tick();
    chk("flags_csr_alu", f_flags, 5'b00100);
    idle();

    // fcsr then frm write
    csr_we = 1; csr_sel = 2'b11; csr_wdata = 8'hE5; tick();
    chk("fcsr_frm", f_frm_out, 3'b111); chk("fcsr_flags", f_flags, 5'b00101);
    csr_sel = 2'b10; csr_wdata = 8'h02; tick();
    chk("frm_frm", f_frm_out, 3'b010); chk("frm_flags", f_flags, 5'b00101);
    csr_we = 0; csr_sel = 2'b11; csr_wdata = 8'hFF; tick();
    chk("csr_we_low", f_frm_out, 3'b010);
    idle();

    // lone load requester, back to back, including f0
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(i * 3); ld_data = 32'hC0DE_0000 + 32'(i);
      tick();
      chk("lone_wen", f_wen, 1); chk("lone_rd", f_rd, 32'(i * 3));
      chk("lone_data", f_w_data, 32'hC0DE_0000 + 32'(i));
    end
    idle();
    tick();
    chk("lone_after_wen", f_wen, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      alu_valid = ($urandom_range(0, 2) != 0);
      alu_rd = 5'($urandom); alu_data = $urandom; alu_flags = 5'($urandom);
      ld_valid = ($urandom_range(0, 2) != 0);
      ld_rd = 5'($urandom); ld_data = $urandom;
      wb_stall = ($urandom_range(0, 3) == 0);
      csr_we = ($urandom_range(0, 7) == 0);
      csr_sel = 2'($urandom); csr_wdata = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_wb_arbiter.md
FPU_WB_ARBITER -- requirements
Module: fpu_wb_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, FP register write-data width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state on rising edge
- nrst  in  1  asynchronous, active-low reset
- alu_valid  in  1  FPU arithmetic result pending
- alu_ready  out  1  alu result accepted this cycle
- alu_rd  in  5  alu destination FP register
- alu_data  in  DATA_W  alu result
- alu_flags  in  5  {NV,DZ,OF,UF,NX} of alu result
- ld_valid  in  1  FP load (FLW) data pending
- ld_ready  out  1  load data accepted this cycle
- ld_rd  in  5  load destination FP register
- ld_data  in  DATA_W  load data
- wb_stall  in  1  register-file write port unavailable
- csr_we  in  1  CSR write strobe
- csr_sel  in  2  01 fflags, 10 frm, 11 fcsr, 00 none
- csr_wdata  in  8  CSR write value (fcsr layout {frm[2:0],fflags[4:0]})
- f_wen  out  1  register-file write enable
- f_rd  out  5  register-file write address
- f_w_data  out  DATA_W  register-file write data
- f_flags  out  5  sticky accrued exception flags
- f_frm_out  out  3  dynamic rounding mode

Function
REQ-003 SHALL arbitrate alu and ld requesters onto the single register-file write port, at most one grant per cycle.
REQ-004 SHALL drive alu_ready/ld_ready combinationally; handshake = valid && ready in the same cycle.
REQ-005 SHALL hold both readies low while wb_stall=1; no handshake, no state change except CSR writes.
REQ-006 SHALL grant a lone valid requester immediately when wb_stall=0.
REQ-007 SHALL, when both valid and wb_stall=0, grant per 1-bit priority pointer prio: prio=0 -> alu, prio=1 -> ld.
REQ-008 SHALL update prio after every grant: alu grant -> prio=1, ld grant -> prio=0; no grant -> unchanged.
REQ-009 SHALL register the granted write: f_wen=1, f_rd, f_w_data valid exactly one cycle after the handshake (latency 1).
REQ-010 SHALL drive f_wen=0 in any cycle following a non-handshake cycle; f_rd/f_w_data hold last value when f_wen=0.
REQ-011 SHALL NOT suppress writes to f0 (FP register 0 is architectural).
REQ-012 SHALL, on alu handshake, OR alu_flags into f_flags at the same edge the write is registered; ld handshakes leave f_flags unchanged.
REQ-013 SHALL apply CSR writes at the edge: sel 01 -> f_flags=wdata[4:0]; 10 -> f_frm_out=wdata[2:0]; 11 -> both; 00 or csr_we=0 -> none.
REQ-014 SHALL, on simultaneous CSR fflags write and alu handshake, set f_flags = csr_wdata[4:0] | alu_flags.
REQ-015 SHALL not assert a ready whose valid is low; requesters may drop valid without handshake.
REQ-016 SHALL ignore csr_sel/csr_wdata while csr_we=0.

Reset
REQ-017 SHALL on nrst=0 immediately set f_wen=0, f_rd=0, f_w_data=0, f_flags=0, f_frm_out=0 (RNE), prio=0.
REQ-018 SHALL drop any handshake in flight at reset assertion; first grant possible in first cycle after nrst rises.
REQ-019 SHALL force alu_ready=ld_ready=0 while nrst=0.

Verification
REQ-020 Reset mid-write: handshake alu rd=3 then nrst=0 before next edge -> f_wen=0, all outputs 0, prio=0.
REQ-021 Conflict: alu(rd=1,data=0x3F800000) and ld(rd=2,data=0x40000000) both valid 2 cycles after reset -> cycle+1 f_wen rd=1, cycle+2 f_wen rd=2; alternation continues.
REQ-022 Stall: both valid, wb_stall=1 for 3 cycles -> readies 0, f_wen 0; on release alu granted first (prio=0).
REQ-023 Flags: alu flags 5'b00001 then 5'b10000 -> f_flags=5'b10001; fflags CSR write 0 same cycle as alu flags 5'b00100 -> 5'b00100.
REQ-024 CSR: fcsr write 8'hE5 -> f_frm_out=3'b111, f_flags=5'b00101; frm write 8'h02 -> f_frm_out=3'b010, flags unchanged.
REQ-025 Lone requester: only ld_valid for 4 back-to-back cycles -> ld_ready=1 each cycle, 4 consecutive f_wen pulses with matching rd/data.
